cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter RUN_DIV, default 50000: base clk cycles between run-mode CPU enables.
REQ-002 SHALL have parameter RST_CYC, default 16: clk cycles cpu_rst is held after a reset request.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port BTN_OK  input  4  debounced button levels: [0] step, [1] run/halt toggle, [2] CPU reset, [3] clear step count.
REQ-006 SHALL have port SW_OK  input  8  debounced switches; [1:0] run-speed select; [7:2] ignored.
REQ-007 SHALL have port cpu_clk_en  output  1  one-cycle pulse that advances the CPU one instruction.
REQ-008 SHALL have port cpu_rst  output  1  active-high CPU reset.
REQ-009 SHALL have port state  output  2  current FSM state encoding.
REQ-010 SHALL have port step_cnt  output  16  count of cpu_clk_en pulses issued.

Function
REQ-011 SHALL detect a press as a 0->1 transition of BTN_OK[i] against a registered copy; one event per press, regardless of hold length.
REQ-012 SHALL take press events one cycle after the input rises: registered compare, no combinational path from BTN_OK to outputs.
REQ-013 SHALL implement states RSTH=2'b00, HALT=2'b01, STEP=2'b10, RUN=2'b11.
REQ-014 SHALL apply per-cycle event priority: reset > clear > run/halt toggle > step; lower-priority events in the same cycle are discarded.
REQ-015 SHALL go to RSTH from any state on a reset press.
REQ-016 SHALL hold cpu_rst=1 in RSTH for exactly RST_CYC cycles, then go to HALT with cpu_rst=0.
REQ-017 SHALL restart the RST_CYC count on a reset press received while in RSTH.
REQ-018 SHALL ignore all other presses while in RSTH.
REQ-019 SHALL go HALT->STEP on a step press; STEP SHALL last one cycle with cpu_clk_en=1, then return to HALT.
REQ-020 SHALL go HALT->RUN on a toggle press, and RUN->HALT on a toggle press.
REQ-021 SHALL ignore step presses while in RUN.
REQ-022 SHALL, in RUN, pulse cpu_clk_en for one cycle every P cycles, where P = RUN_DIV << SW_OK[1:0].
REQ-023 SHALL issue the first run-mode pulse P cycles after entering RUN, with the period counter cleared on RUN entry.
REQ-024 SHALL sample SW_OK[1:0] when the period counter reloads, so a speed change takes effect from the next period.
REQ-025 SHALL not issue a pending run-mode pulse on a RUN->HALT toggle; the period counter is discarded.
REQ-026 SHALL size the period counter to hold RUN_DIV<<3 without overflow.
REQ-027 SHALL assert cpu_clk_en only in STEP or on a RUN period expiry, and never while cpu_rst=1.
REQ-028 SHALL increment step_cnt on every cpu_clk_en pulse, wrapping 16'hFFFF -> 16'h0000.
REQ-029 SHALL clear step_cnt on entry to RSTH or on a clear press.
REQ-030 SHALL let a clear press in the same cycle as a cpu_clk_en pulse win, leaving step_cnt at 0.
REQ-031 SHALL not change the state on a clear press.

Reset
REQ-032 SHALL, while rst=0, force state=RSTH, cpu_rst=1, cpu_clk_en=0, step_cnt=0, period counter=0 and the RSTH counter=0.
REQ-033 SHALL reset the registered button copy to 4'hF, so a button held through reset generates no event.
REQ-034 SHALL, after rst deasserts, complete the RST_CYC hold and enter HALT.

Verification
REQ-035 SHALL cover: release rst with BTN_OK=0 -> cpu_rst=1 for 16 cycles, then state=01, cpu_clk_en=0.
REQ-036 SHALL cover: in HALT, press step three times -> exactly 3 single-cycle cpu_clk_en pulses, step_cnt=3.
REQ-037 SHALL cover: RUN_DIV=10, SW_OK=8'h02, toggle -> pulses every 40 cycles; toggle again -> pulses stop, state=01.
REQ-038 SHALL cover: in RUN, press reset and step in the same cycle -> state=00, cpu_rst=1, no pulse, step_cnt=0.
REQ-039 SHALL cover: preload step_cnt to 16'hFFFF via steps, step once -> step_cnt=0; clear coincident with a pulse -> step_cnt=0.
REQ-040 SHALL cover: hold BTN_OK[0]=1 through rst deassert -> no STEP; release and press -> one pulse.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/reset controller for a single-step CPU: turns debounced button presses
// into a timed CPU reset, single-step pulses and a free-running clock-enable.
module cpu_run_ctrl #(
  parameter int RUN_DIV = 50000,
  parameter int RST_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  BTN_OK,
  input  logic [7:0]  SW_OK,
  output logic        cpu_clk_en,
  output logic        cpu_rst,
  output logic [1:0]  state,
  output logic [15:0] step_cnt
);

  localparam logic [1:0] RSTH = 2'b00;
  localparam logic [1:0] HALT = 2'b01;
  localparam logic [1:0] STEP = 2'b10;
  localparam logic [1:0] RUN  = 2'b11;

  localparam int CW = $clog2(RUN_DIV * 8 + 1);
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);
  localparam logic [CW-1:0] DIV      = CW'(RUN_DIV);

  logic [1:0]    state_reg, state_next;
  logic [RW-1:0] rst_cnt_reg, rst_cnt_next;
  logic [CW-1:0] per_cnt_reg, per_cnt_next;
  logic [1:0]    speed_reg, speed_next;
  logic          pulse_reg, pulse_next;
  logic [15:0]   step_cnt_reg, step_cnt_next;
  logic [3:0]    btn_prev_reg;
  logic [3:0]    press;
  logic          ev_rst, ev_clr, ev_tog, ev_step;
  logic [CW-1:0] period;
  logic          expiry, run_stay;
  logic          unused_sw;

  assign unused_sw = ^SW_OK[7:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_press
      assign press[gi] = BTN_OK[gi] & ~btn_prev_reg[gi];
    end
  endgenerate

  // Only the highest-priority press of a cycle survives
  assign ev_rst  = press[2];
  assign ev_clr  = press[3] & ~press[2];
  assign ev_tog  = press[1] & ~(|press[3:2]);
  assign ev_step = press[0] & ~(|press[3:1]);

  assign period   = DIV << speed_reg;
  assign expiry   = (per_cnt_reg == period - CW'(1));
  assign run_stay = (state_reg == RUN) && (state_next == RUN);

  always_comb begin
    state_next   = state_reg;
    rst_cnt_next = '0;
    if (ev_rst) begin
      state_next = RSTH;
    end else begin
      case (state_reg)
        RSTH: begin
          if (rst_cnt_reg == RST_LAST) begin
            state_next = HALT;
          end else begin
            rst_cnt_next = rst_cnt_reg + RW'(1);
          end
        end
        HALT: begin
          if (ev_tog) begin
            state_next = RUN;
          end else if (ev_step) begin
            state_next = STEP;
          end
        end
        STEP:    state_next = HALT;
        RUN:     if (ev_tog) state_next = HALT;
        default: state_next = RSTH;
      endcase
    end
  end

  // Period counter restarts on RUN entry and on each expiry; leaving RUN drops it
  always_comb begin
    per_cnt_next = '0;
    speed_next   = speed_reg;
    pulse_next   = 1'b0;
    if (run_stay && !expiry) begin
      per_cnt_next = per_cnt_reg + CW'(1);
    end
    if (run_stay && expiry) begin
      pulse_next = 1'b1;
    end
    if ((state_next == RUN) && ((state_reg != RUN) || expiry)) begin
      speed_next = SW_OK[1:0];
    end
  end

  always_comb begin
    step_cnt_next = step_cnt_reg;
    if (ev_rst || ev_clr) begin
      step_cnt_next = '0;
    end else if (cpu_clk_en) begin
      step_cnt_next = step_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= RSTH;
      rst_cnt_reg  <= '0;
      per_cnt_reg  <= '0;
      speed_reg    <= '0;
      pulse_reg    <= 1'b0;
      step_cnt_reg <= '0;
      btn_prev_reg <= 4'hF;
    end else begin
      state_reg    <= state_next;
      rst_cnt_reg  <= rst_cnt_next;
      per_cnt_reg  <= per_cnt_next;
      speed_reg    <= speed_next;
      pulse_reg    <= pulse_next;
      step_cnt_reg <= step_cnt_next;
      btn_prev_reg <= BTN_OK;
    end
  end

  assign state      = state_reg;
  assign cpu_rst    = (state_reg == RSTH);
  assign cpu_clk_en = (state_reg == STEP) | pulse_reg;
  assign step_cnt   = step_cnt_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: vector table, hand sequences, and random presses
// checked against a countdown-based reference model; a second instance checks wrap.
module tb_cpu_run_ctrl;

  localparam int RUN_DIV = 10;
  localparam int RST_CYC = 16;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [3:0]  btn, btn2;
  logic [7:0]  sw, sw2;
  logic        en, crst, en2, crst2;
  logic [1:0]  st, st2;
  logic [15:0] cnt, cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.RUN_DIV(RUN_DIV), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rst(rst), .BTN_OK(btn), .SW_OK(sw),
    .cpu_clk_en(en), .cpu_rst(crst), .state(st), .step_cnt(cnt)
  );

  cpu_run_ctrl #(.RUN_DIV(1), .RST_CYC(2)) dut_wrap (
    .clk(clk), .rst(rst2), .BTN_OK(btn2), .SW_OK(sw2),
    .cpu_clk_en(en2), .cpu_rst(crst2), .state(st2), .step_cnt(cnt2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: modes 0 reset-hold, 1 halt, 2 step, 3 run; countdowns instead of counters
  int          m_mode, m_hold, m_wait;
  logic        m_pulse;
  logic [15:0] m_cnt;
  logic [3:0]  m_prev;

  function automatic void m_reset();
    m_mode = 0; m_hold = RST_CYC; m_wait = 0;
    m_pulse = 1'b0; m_cnt = 16'd0; m_prev = 4'hF;
  endfunction

  function automatic void m_step(input logic [3:0] b, input logic [7:0] s);
    logic [3:0] pr;
    logic       fired;
    pr = b & ~m_prev;
    fired = (m_mode == 2) || m_pulse;
    m_prev = b;
    m_pulse = 1'b0;
    if (pr[2]) begin
      m_mode = 0; m_hold = RST_CYC; m_cnt = 16'd0;
      return;
    end
    if (m_mode == 0) begin
      m_hold--;
      if (m_hold == 0) m_mode = 1;
      return;
    end
    m_cnt = pr[3] ? 16'd0 : m_cnt + {15'd0, fired};
    if (m_mode == 2) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (!pr[3] && pr[1]) begin
        m_mode = 3; m_wait = RUN_DIV << s[1:0];
      end else if (!pr[3] && pr[0]) begin
        m_mode = 2;
      end
    end else begin
      if (!pr[3] && pr[1]) begin
        m_mode = 1;
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          m_pulse = 1'b1; m_wait = RUN_DIV << s[1:0];
        end
      end
    end
  endfunction

  task automatic tick(input logic [3:0] b, input logic [7:0] s);
    btn = b; sw = s;
    @(posedge clk);
    m_step(b, s);
    #1;
    chk("model_state", int'(st), m_mode);
    chk("model_cpu_rst", int'(crst), int'(m_mode == 0));
    chk("model_cpu_clk_en", int'(en), int'((m_mode == 2) || m_pulse));
    chk("model_step_cnt", int'(cnt), int'(m_cnt));
  endtask

  task automatic tick2(input logic [3:0] b);
    btn2 = b;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  b;
    logic [1:0]  st;
    logic        en;
    logic        crst;
    logic [15:0] cnt;
  } vec_t;

  task automatic main_seq();
    vec_t vecs[15];
    int   pulses[$];
    int   n;
    vecs[0]  = '{4'b0001, 2'b10, 1'b1, 1'b0, 16'd0};
    vecs[1]  = '{4'b0001, 2'b01, 1'b0, 1'b0, 16'd1};
    vecs[2]  = '{4'b0000, 2'b01, 1'b0, 1'b0, 16'd1};
    vecs[3]  = '{4'b0001, 2'b10, 1'b1, 1'b0, 16'd1};
    vecs[4]  = '{4'b0000, 2'b01, 1'b0, 1'b0, 16'd2};
    vecs[5]  = '{4'b0001, 2'b10, 1'b1, 1'b0, 16'd2};
    vecs[6]  = '{4'b0000, 2'b01, 1'b0, 1'b0, 16'd3};
    vecs[7]  = '{4'b1000, 2'b01, 1'b0, 1'b0, 16'd0};
    vecs[8]  = '{4'b0010, 2'b11, 1'b0, 1'b0, 16'd0};
    vecs[9]  = '{4'b0010, 2'b11, 1'b0, 1'b0, 16'd0};
    vecs[10] = '{4'b0000, 2'b11, 1'b0, 1'b0, 16'd0};
    vecs[11] = '{4'b0011, 2'b01, 1'b0, 1'b0, 16'd0};
    vecs[12] = '{4'b0000, 2'b01, 1'b0, 1'b0, 16'd0};
    vecs[13] = '{4'b0100, 2'b00, 1'b0, 1'b1, 16'd0};
    vecs[14] = '{4'b0010, 2'b00, 1'b0, 1'b1, 16'd0};

    // Reset hold after release with no buttons
    for (int i = 1; i <= RST_CYC; i++) begin
      tick(4'h0, 8'h00);
      if (i < RST_CYC) chk("rst_hold_cpu_rst", int'(crst), 1);
    end
    chk("rst_done_state", int'(st), 1);
    chk("rst_done_cpu_rst", int'(crst), 0);
    chk("rst_done_en", int'(en), 0);
    $display("seq reset-hold done: state=%0d", st);

    for (int i = 0; i < 15; i++) begin
      tick(vecs[i].b, 8'h00);
      chk("vec_state", int'(st), int'(vecs[i].st));
      chk("vec_en", int'(en), int'(vecs[i].en));
      chk("vec_cpu_rst", int'(crst), int'(vecs[i].crst));
      chk("vec_step_cnt", int'(cnt), int'(vecs[i].cnt));
      $display("vec %0d: btn=%b state=%0d en=%0d cpu_rst=%0d step_cnt=%0d",
               i, vecs[i].b, st, en, crst, cnt);
    end
    repeat (20) tick(4'h0, 8'h00);

    // Run at speed 2: period RUN_DIV<<2
    tick(4'b0010, 8'h02);
    for (int k = 1; k <= 125; k++) begin
      tick(4'h0, 8'h02);
      if (en) pulses.push_back(k);
    end
    chk("run_pulse_count", pulses.size(), 3);
    for (int i = 0; i < pulses.size() && i < 3; i++)
      chk("run_pulse_cycle", pulses[i], 40 * (i + 1));
    tick(4'b0010, 8'h02);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      tick(4'h0, 8'h02);
      n += int'(en);
    end
    chk("halt_no_pulse", n, 0);
    chk("halt_state", int'(st), 1);
    $display("seq run/halt done: pulses=%0d step_cnt=%0d", pulses.size(), cnt);

    // Reset and step together while running
    tick(4'b0010, 8'h00);
    repeat (5) tick(4'h0, 8'h00);
    tick(4'b0101, 8'h00);
    chk("rst_step_state", int'(st), 0);
    chk("rst_step_cpu_rst", int'(crst), 1);
    chk("rst_step_en", int'(en), 0);
    chk("rst_step_cnt", int'(cnt), 0);
    $display("seq reset+step in run: state=%0d step_cnt=%0d", st, cnt);
    repeat (20) tick(4'h0, 8'h00);

    // Step held through an asynchronous reset
    btn = 4'b0001; rst = 1'b0; m_reset();
    #1;
    chk("async_rst_state", int'(st), 0);
    chk("async_rst_cnt", int'(cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    n = 0;
    for (int k = 0; k < 25; k++) begin
      tick(4'b0001, 8'h00);
      n += int'(en);
    end
    chk("held_no_step", n, 0);
    chk("held_state", int'(st), 1);
    tick(4'h0, 8'h00);
    tick(4'b0001, 8'h00);
    chk("held_then_press_en", int'(en), 1);
    tick(4'h0, 8'h00);
    chk("held_then_press_done", int'(en), 0);
    $display("seq held-through-reset done: step_cnt=%0d", cnt);

    for (int k = 0; k < 4000; k++) begin
      logic [3:0] b;
      b[0] = ($urandom_range(999, 0) < 80);
      b[1] = ($urandom_range(999, 0) < 10);
      b[2] = ($urandom_range(999, 0) < 4);
      b[3] = ($urandom_range(999, 0) < 20);
      tick(b, 8'($urandom));
    end
    $display("seq random done: state=%0d step_cnt=%0d", st, cnt);
  endtask

  task automatic wrap_seq();
    int n;
    @(posedge clk);
    #1 rst2 = 1'b1;
    repeat (5) tick2(4'h0);
    chk("wrap_halt", int'(st2), 1);
    tick2(4'b0010);
    tick2(4'h0);
    tick2(4'h0);
    chk("wrap_run_en", int'(en2), 1);
    n = 0;
    while (cnt2 != 16'hFFFD && n < 70000) begin
      tick2(4'h0);
      n++;
    end
    chk("wrap_reach", int'(cnt2), 16'hFFFD);
    tick2(4'b0010);
    chk("wrap_stop_state", int'(st2), 1);
    chk("wrap_stop_cnt", int'(cnt2), 16'hFFFE);
    tick2(4'h0);
    tick2(4'b0001);
    tick2(4'h0);
    chk("wrap_ffff", int'(cnt2), 16'hFFFF);
    tick2(4'b0001);
    tick2(4'h0);
    chk("wrap_zero", int'(cnt2), 0);
    $display("seq wrap: step_cnt=%0d after wrap", cnt2);
    tick2(4'b0001);
    tick2(4'h0);
    tick2(4'b0001);
    chk("clr_pulse_en", int'(en2), 1);
    tick2(4'b1000);
    chk("clr_pulse_cnt", int'(cnt2), 0);
    chk("clr_pulse_state", int'(st2), 1);
    $display("seq clear-vs-pulse: step_cnt=%0d state=%0d", cnt2, st2);
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    btn = 4'h0; btn2 = 4'h0; sw = 8'h00; sw2 = 8'h00;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(st), 0);
    chk("reset_cpu_rst", int'(crst), 1);
    chk("reset_en", int'(en), 0);
    chk("reset_cnt", int'(cnt), 0);
    rst = 1'b1;
    fork
      main_seq();
      wrap_seq();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
